// File: rtl/ammo_controller.sv
// Magazine/fire-rate controller: turns fire-button edges into one-cycle shot pulses,
// enforces a frame-based cooldown between shots and a frame-based reload when empty.
module ammo_controller #(
   parameter int unsigned MAX_AMMO        = 5,
   parameter int unsigned COOLDOWN_FRAMES = 8,
   parameter int unsigned RELOAD_FRAMES   = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       fire_req,
   input  logic       reload_req,
   output logic [2:0] count,
   output logic       shot,
   output logic       reloading,
   output logic       empty,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      StReady    = 2'd0,
      StCooldown = 2'd1,
      StReload   = 2'd2
   } state_e;

   localparam logic [2:0] MaxCount   = 3'(MAX_AMMO);
   localparam logic [7:0] CoolLoad   = 8'(COOLDOWN_FRAMES);
   localparam logic [7:0] ReloadLoad = 8'(RELOAD_FRAMES);

   state_e     state_q, state_d;
   logic [7:0] timer_q, timer_d;
   logic [2:0] count_q, count_d;
   logic       shot_q, shot_d;
   logic       fire_prev_q;
   logic       fire_edge;

   assign fire_edge = fire_req & ~fire_prev_q;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      count_d = count_q;
      shot_d  = 1'b0;
      unique case (state_q)
         StReady: begin
            // A fire edge takes precedence; a coincident reload_req is dropped.
            if (fire_edge) begin
               if (count_q != 3'd0) begin
                  shot_d  = 1'b1;
                  count_d = count_q - 3'd1;
                  timer_d = CoolLoad;
                  state_d = StCooldown;
               end else begin
                  timer_d = ReloadLoad;
                  state_d = StReload;
               end
            end else if (reload_req && (count_q < MaxCount)) begin
               timer_d = ReloadLoad;
               state_d = StReload;
            end
         end
         StCooldown: begin
            if (frame_tick) begin
               if (timer_q <= 8'd1) begin
                  timer_d = 8'd0;
                  if (count_q == 3'd0) begin
                     timer_d = ReloadLoad;
                     state_d = StReload;
                  end else begin
                     state_d = StReady;
                  end
               end else begin
                  timer_d = timer_q - 8'd1;
               end
            end
         end
         StReload: begin
            if (frame_tick) begin
               if (timer_q <= 8'd1) begin
                  timer_d = 8'd0;
                  count_d = MaxCount;
                  state_d = StReady;
               end else begin
                  timer_d = timer_q - 8'd1;
               end
            end
         end
         default: begin
            timer_d = 8'd0;
            state_d = StReady;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StReady;
         timer_q     <= 8'd0;
         count_q     <= MaxCount;
         shot_q      <= 1'b0;
         // Held high so a button pressed across reset needs a fresh press.
         fire_prev_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         count_q     <= count_d;
         shot_q      <= shot_d;
         fire_prev_q <= fire_req;
      end
   end

   assign count     = count_q;
   assign shot      = shot_q;
   assign reloading = (state_q == StReload);
   assign empty     = (count_q == 3'd0);
   assign state     = state_q;

endmodule
